bcd_updown_display: RTL and testbench

BCD_UPDOWN_DISPLAY -- requirements
Module: bcd_updown_display

---
 rtl/bcd_disp_pkg.sv | 41 ++++
 rtl/bcd_updown_display_seg7_encoder.sv | 23 ++
 rtl/bcd_updown_display.sv | 130 +++++++++++++
 tb/tb_bcd_updown_display.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/bcd_disp_pkg.sv
// Shared types and seven-segment constants for the BCD up/down display.
// Patterns are active-low: bits [7:1] = a..g, bit 0 = dp (kept dark).
package bcd_disp_pkg;

  typedef enum logic [1:0] {
    MODE_UP    = 2'd0,
    MODE_DOWN  = 2'd1,
    MODE_CLEAR = 2'd2
  } mode_t;

  localparam logic [7:0] SEG_0     = 8'h03;
  localparam logic [7:0] SEG_1     = 8'h9F;
  localparam logic [7:0] SEG_2     = 8'h25;
  localparam logic [7:0] SEG_3     = 8'h0D;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h49;
  localparam logic [7:0] SEG_6     = 8'h41;
  localparam logic [7:0] SEG_7     = 8'h1F;
  localparam logic [7:0] SEG_8     = 8'h01;
  localparam logic [7:0] SEG_9     = 8'h09;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  function automatic logic [7:0] seg_pattern(input logic [3:0] digit);
    logic [7:0] pat;
    case (digit)
      4'd0:    pat = SEG_0;
      4'd1:    pat = SEG_1;
      4'd2:    pat = SEG_2;
      4'd3:    pat = SEG_3;
      4'd4:    pat = SEG_4;
      4'd5:    pat = SEG_5;
      4'd6:    pat = SEG_6;
      4'd7:    pat = SEG_7;
      4'd8:    pat = SEG_8;
      4'd9:    pat = SEG_9;
      default: pat = SEG_BLANK;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/bcd_updown_display_seg7_encoder.sv
// Registered nibble-to-segment encoder for one display digit.
// Blanked digits and non-BCD nibbles drive all segments dark.
module seg7_encoder
  import bcd_disp_pkg::*;
#(
  parameter logic [7:0] RST_PAT = SEG_0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [7:0] segm
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      segm <= RST_PAT;
    end else begin
      segm <= blank ? SEG_BLANK : seg_pattern(digit);
    end
  end

endmodule

// File: rtl/bcd_updown_display.sv
// Multi-digit BCD up/down counter driven by two active-low buttons,
// with a free-running tick prescaler and registered 7-segment outputs.
module bcd_updown_display
  import bcd_disp_pkg::*;
#(
  parameter int DIGITS   = 2,
  parameter int TICK_DIV = 20000000,
  parameter int WRAP     = 1,
  parameter int BLANK_LZ = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  count_up,
  input  logic                  count_down,
  output logic [4*DIGITS-1:0]   count_o,
  output logic [8*DIGITS-1:0]   segm_o,
  output logic                  dir_o
);

  localparam int CW = 4 * DIGITS;
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] DIV_LAST = PW'(TICK_DIV - 1);

  logic          up_p0, up_p1, dn_p0, dn_p1;
  logic [PW-1:0] presc;
  logic          tick;
  mode_t         state, state_next;
  logic [DIGITS-1:0] blank;
  logic          all_zero;

  // One decimal step with carry/borrow; without WRAP the end values stick.
  function automatic logic [CW-1:0] bcd_step(input logic [CW-1:0] v, input logic up);
    logic [CW-1:0] r;
    logic          carry;
    logic          at_end;
    r      = v;
    carry  = 1'b1;
    at_end = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      at_end = at_end & (v[4*i +: 4] == (up ? 4'd9 : 4'd0));
      if (carry) begin
        if (up) begin
          if (v[4*i +: 4] == 4'd9) r[4*i +: 4] = 4'd0;
          else begin
            r[4*i +: 4] = v[4*i +: 4] + 4'd1;
            carry       = 1'b0;
          end
        end else begin
          if (v[4*i +: 4] == 4'd0) r[4*i +: 4] = 4'd9;
          else begin
            r[4*i +: 4] = v[4*i +: 4] - 4'd1;
            carry       = 1'b0;
          end
        end
      end
    end
    if (at_end && (WRAP == 0)) r = v;
    return r;
  endfunction

  // Stage p0/p1: button synchronisers, idle high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      up_p0 <= 1'b1;
      up_p1 <= 1'b1;
      dn_p0 <= 1'b1;
      dn_p1 <= 1'b1;
    end else begin
      up_p0 <= count_up;
      up_p1 <= up_p0;
      dn_p0 <= count_down;
      dn_p1 <= dn_p0;
    end
  end

  assign tick = (presc == DIV_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) presc <= '0;
    else     presc <= tick ? '0 : presc + PW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= MODE_UP;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case ({up_p1, dn_p1})
      2'b01:   state_next = MODE_UP;
      2'b10:   state_next = MODE_DOWN;
      2'b00:   state_next = MODE_CLEAR;
      default: if (state == MODE_CLEAR) state_next = MODE_UP;
    endcase
  end

  assign dir_o = (state != MODE_DOWN);

  // CLEAR wins over a coincident tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              count_o <= '0;
    else if (state == MODE_CLEAR)         count_o <= '0;
    else if (tick && state == MODE_UP)    count_o <= bcd_step(count_o, 1'b1);
    else if (tick && state == MODE_DOWN)  count_o <= bcd_step(count_o, 1'b0);
  end

  always_comb begin
    blank    = '0;
    all_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      all_zero = all_zero & (count_o[4*i +: 4] == 4'd0);
      blank[i] = (BLANK_LZ != 0) && all_zero;
    end
  end

  // Stage p2: registered segment patterns, one cycle behind count_o.
  for (genvar g = 0; g < DIGITS; g++) begin : g_enc
    seg7_encoder #(
      .RST_PAT((g == 0 || BLANK_LZ == 0) ? SEG_0 : SEG_BLANK)
    ) u_enc (
      .clk   (clk),
      .rst   (rst),
      .digit (count_o[4*g +: 4]),
      .blank (blank[g]),
      .segm  (segm_o[8*g +: 8])
    );
  end

endmodule

// File: tb/tb_bcd_updown_display.sv
// Randomised check of two display configurations (wrap/no-blank and
// saturate/blank-leading-zero) against an integer-valued reference model.
module tb_bcd_updown_display;

  localparam int TD   = 4;
  localparam int MAXV = 99;
  localparam logic [7:0] SEG_TBL [0:9] =
    '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F, 8'h01, 8'h09};

  logic        clk;
  logic        rst;
  logic        count_up;
  logic        count_down;
  logic [7:0]  count_a, count_b;
  logic [15:0] segm_a, segm_b;
  logic        dir_a, dir_b;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: plain integers for the shown value, mode 0=up 1=down 2=clear.
  int m_val   [2];
  int m_shown [2];
  int m_div;
  int m_mode;
  bit up_pipe [2];
  bit dn_pipe [2];

  bcd_updown_display #(.DIGITS(2), .TICK_DIV(TD), .WRAP(1), .BLANK_LZ(0)) u_dut_a (
    .clk(clk), .rst(rst), .count_up(count_up), .count_down(count_down),
    .count_o(count_a), .segm_o(segm_a), .dir_o(dir_a)
  );

  bcd_updown_display #(.DIGITS(2), .TICK_DIV(TD), .WRAP(0), .BLANK_LZ(1)) u_dut_b (
    .clk(clk), .rst(rst), .count_up(count_up), .count_down(count_down),
    .count_o(count_b), .segm_o(segm_b), .dir_o(dir_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        m_val[k]   = 0;
        m_shown[k] = 0;
      end
      m_div      = 0;
      m_mode     = 0;
      up_pipe[0] = 1'b1; up_pipe[1] = 1'b1;
      dn_pipe[0] = 1'b1; dn_pipe[1] = 1'b1;
    end else begin
      bit tick;
      tick = (m_div == TD - 1);
      for (int k = 0; k < 2; k++) begin
        m_shown[k] = m_val[k];
        if (m_mode == 2) m_val[k] = 0;
        else if (tick && m_mode == 0)
          m_val[k] = (m_val[k] == MAXV) ? ((k == 0) ? 0 : MAXV) : m_val[k] + 1;
        else if (tick && m_mode == 1)
          m_val[k] = (m_val[k] == 0) ? ((k == 0) ? MAXV : 0) : m_val[k] - 1;
      end
      m_div = tick ? 0 : m_div + 1;
      if (!up_pipe[1] && dn_pipe[1])       m_mode = 0;
      else if (up_pipe[1] && !dn_pipe[1])  m_mode = 1;
      else if (!up_pipe[1] && !dn_pipe[1]) m_mode = 2;
      else if (m_mode == 2)                m_mode = 0;
      up_pipe[1] = up_pipe[0]; up_pipe[0] = count_up;
      dn_pipe[1] = dn_pipe[0]; dn_pipe[0] = count_down;
    end
  end

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic logic [15:0] exp_seg(input int v, input bit blank_lz);
    logic [7:0] hi;
    hi = (blank_lz && (v / 10) == 0) ? 8'hFF : SEG_TBL[v / 10];
    return {hi, SEG_TBL[v % 10]};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    check_eq("count_a", 32'(count_a), 32'(to_bcd(m_val[0])));
    check_eq("segm_a",  32'(segm_a),  32'(exp_seg(m_shown[0], 1'b0)));
    check_eq("dir_a",   32'(dir_a),   32'(m_mode != 1));
    check_eq("count_b", 32'(count_b), 32'(to_bcd(m_val[1])));
    check_eq("segm_b",  32'(segm_b),  32'(exp_seg(m_shown[1], 1'b1)));
    check_eq("dir_b",   32'(dir_b),   32'(m_mode != 1));
  endtask

  task automatic step_cycle(input logic up, input logic dn);
    @(negedge clk);
    check_all();
    count_up   = up;
    count_down = dn;
  endtask

  task automatic async_reset();
    @(negedge clk);
    check_all();
    #2 rst = 1'b1;
    #1;
    check_eq("rst_count_a", 32'(count_a), 32'h00);
    check_eq("rst_segm_a",  32'(segm_a),  32'h0303);
    check_eq("rst_count_b", 32'(count_b), 32'h00);
    check_eq("rst_segm_b",  32'(segm_b),  32'hFF03);
    check_eq("rst_dir_a",   32'(dir_a),   32'h1);
    check_all();
    @(negedge clk);
    check_all();
    rst = 1'b0;
  endtask

  initial begin
    int sel;
    int len;
    rst        = 1'b0;
    count_up   = 1'b1;
    count_down = 1'b1;
    #1 rst = 1'b1;
    repeat (3) step_cycle(1'b1, 1'b1);
    @(negedge clk);
    check_all();
    rst = 1'b0;

    repeat (40) step_cycle(1'b1, 1'b1);
    repeat (3)  step_cycle(1'b1, 1'b0);
    repeat (60) step_cycle(1'b1, 1'b1);
    repeat (3)  step_cycle(1'b0, 1'b0);
    repeat (450) step_cycle(1'b1, 1'b1);
    repeat (3)  step_cycle(1'b1, 1'b0);
    repeat (20) step_cycle(1'b1, 1'b1);
    repeat (3)  step_cycle(1'b0, 1'b1);
    repeat (30) step_cycle(1'b1, 1'b1);

    repeat (300) begin
      sel = $urandom_range(0, 19);
      len = $urandom_range(1, 8);
      if (sel == 19) async_reset();
      else if (sel < 12) repeat (len) step_cycle(1'b1, 1'b1);
      else if (sel < 15) repeat (len) step_cycle(1'b0, 1'b1);
      else if (sel < 17) repeat (len) step_cycle(1'b1, 1'b0);
      else               repeat (len) step_cycle(1'b0, 1'b0);
    end
    repeat (20) step_cycle(1'b1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
